// File: rtl/step_sequencer.sv
// step_sequencer: initiator side of the start/done step-unit handshake.
// Takes a seed and a step count, runs the attached step unit that many
// times (feeding each result back as the next operand), then offers the
// final value, a timeout flag and the completed-step count on a
// valid/ready result port. A per-step watchdog aborts a stalled step unit.
module step_sequencer #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CNT_W-1:0]  cmd_steps,
  output logic              step_start,
  output logic [DATA_W-1:0] step_in_data,
  input  logic              step_done,
  input  logic [DATA_W-1:0] step_out_data,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] result_data,
  output logic              result_err,
  output logic [CNT_W-1:0]  result_steps,
  output logic              busy
);

  // wait_cnt only has to reach TIMEOUT-1
  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESULT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  done_cnt;
  logic [WC_W-1:0]   wait_cnt;

  // The operand is the accumulator register itself, so it is stable
  // through ISSUE and WAIT and returns to zero on reset along with acc.
  assign step_in_data = acc;

  // Sequencer FSM with all handshake and result outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      remaining    <= '0;
      done_cnt     <= '0;
      wait_cnt     <= '0;
      cmd_ready    <= 1'b1;
      step_start   <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_err   <= 1'b0;
      result_steps <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            acc       <= cmd_data;
            remaining <= cmd_steps;
            done_cnt  <= '0;
            cmd_ready <= 1'b0;
            if (cmd_steps == '0) begin
              state        <= RESULT;
              result_valid <= 1'b1;
              result_data  <= cmd_data;
              result_err   <= 1'b0;
              result_steps <= '0;
            end else begin
              state      <= ISSUE;
              step_start <= 1'b1;
              busy       <= 1'b1;
            end
          end
        end

        ISSUE: begin
          step_start <= 1'b0;
          wait_cnt   <= '0;
          state      <= WAIT;
        end

        WAIT: begin
          // A done arriving on the expiry cycle wins over the timeout
          if (step_done) begin
            acc       <= step_out_data;
            done_cnt  <= done_cnt + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state        <= RESULT;
              busy         <= 1'b0;
              result_valid <= 1'b1;
              result_data  <= step_out_data;
              result_err   <= 1'b0;
              result_steps <= done_cnt + 1'b1;
            end else begin
              state      <= ISSUE;
              step_start <= 1'b1;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state        <= RESULT;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            result_data  <= acc;
            result_err   <= 1'b1;
            result_steps <= done_cnt;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESULT: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            cmd_ready    <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed and randomized commands against a step-unit
// responder with programmable per-step latency. Expected results, latency
// and start-pulse counts come from a step-by-step arithmetic model.
module tb_step_sequencer;

  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 15;
  localparam int NEVER   = 1000;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data;
  logic [CNT_W-1:0]  cmd_steps;
  logic              step_start;
  logic [DATA_W-1:0] step_in_data;
  logic              step_done;
  logic [DATA_W-1:0] step_out_data;
  logic              result_valid;
  logic              result_ready;
  logic [DATA_W-1:0] result_data;
  logic              result_err;
  logic [CNT_W-1:0]  result_steps;
  logic              busy;

  always #5 clk = ~clk;

  step_sequencer #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .cmd_steps    (cmd_steps),
    .step_start   (step_start),
    .step_in_data (step_in_data),
    .step_done    (step_done),
    .step_out_data(step_out_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data),
    .result_err   (result_err),
    .result_steps (result_steps),
    .busy         (busy)
  );

  int checks   = 0;
  int failures = 0;

  // responder programming: one latency and one spurious-done flag per start
  int          lat_q[$];
  bit          spur_q[$];
  int          plan_lat[$];
  bit          plan_spur[$];
  int          op_mode;
  logic [7:0]  op_k;
  int          starts_seen;

  function automatic logic [7:0] apply_op(input int mode, input logic [7:0] k,
                                          input logic [7:0] x);
    logic [7:0] r;
    case (mode)
      0:       r = x + x;
      1:       r = x + k;
      default: r = x ^ k;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(99);
    if (r < 60) return 1;
    else if (r < 80) return $urandom_range(TIMEOUT - 1, 2);
    else if (r < 88) return TIMEOUT;
    else if (r < 94) return TIMEOUT + 1;
    else return NEVER;
  endfunction

  // Step-unit responder: done comes L cycles after the start cycle,
  // optionally with a junk done on the start cycle itself.
  initial begin : responder
    int         left;
    int         lat;
    bit         pend;
    logic [7:0] val;
    step_done     = 1'b0;
    step_out_data = '0;
    starts_seen   = 0;
    pend          = 1'b0;
    left          = 0;
    val           = '0;
    forever begin
      @(posedge clk);
      #1;
      step_done = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          left--;
          if (left == 0) begin
            step_done     = 1'b1;
            step_out_data = val;
            pend          = 1'b0;
          end
        end
        if (step_start) begin
          starts_seen++;
          lat = (lat_q.size() > 0) ? lat_q.pop_front() : NEVER;
          if (spur_q.size() > 0 && spur_q.pop_front()) begin
            step_done     = 1'b1;
            step_out_data = 8'($urandom);
          end
          if (lat < NEVER) begin
            pend = 1'b1;
            left = lat;
            val  = apply_op(op_mode, op_k, step_in_data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One full command: model, issue, wait for result, hold, handshake
  task automatic run_cmd(input string tag, input logic [7:0] seed, input int n,
                         input int mode, input logic [7:0] k, input int hold);
    logic [7:0] e_data;
    int         e_steps;
    int         e_starts;
    int         e_lat;
    bit         e_err;
    int         t;
    int         s0;
    logic [31:0] snap;

    e_data   = seed;
    e_steps  = 0;
    e_starts = 0;
    e_lat    = 1;
    e_err    = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!e_err) begin
        e_starts++;
        if (plan_lat[i] <= TIMEOUT) begin
          e_data = apply_op(mode, k, e_data);
          e_steps++;
          e_lat += plan_lat[i] + 1;
        end else begin
          e_err = 1'b1;
          e_lat += TIMEOUT + 1;
        end
      end
    end

    lat_q   = plan_lat;
    spur_q  = plan_spur;
    op_mode = mode;
    op_k    = k;
    s0      = starts_seen;

    t = 0;
    while (!cmd_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({tag, ":cmd_ready_idle"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_data  = seed;
    cmd_steps = CNT_W'(n);
    @(posedge clk);
    #1;
    // junk command held during the run must never be taken
    cmd_valid = (hold > 0);
    cmd_data  = 8'($urandom);
    cmd_steps = CNT_W'($urandom);
    chk({tag, ":cmd_ready_after_accept"}, cmd_ready, 0);

    t = 1;
    while (!result_valid && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({tag, ":latency"}, t, e_lat);
    chk({tag, ":starts"}, starts_seen - s0, e_starts);
    chk({tag, ":data"}, result_data, e_data);
    chk({tag, ":err"}, result_err, e_err);
    chk({tag, ":steps"}, result_steps, e_steps);
    chk({tag, ":busy_in_result"}, busy, 0);

    snap = {20'd0, 1'b1, 1'b0, e_err, CNT_W'(e_steps), e_data};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ":hold_stable"},
          {20'd0, result_valid, cmd_ready, result_err, result_steps, result_data}, snap);
    end

    cmd_valid    = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    chk({tag, ":valid_dropped"}, result_valid, 0);
    chk({tag, ":back_to_idle"}, cmd_ready, 1);
  endtask

  initial begin : stimulus
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_data     = '0;
    cmd_steps    = '0;
    result_ready = 1'b0;
    op_mode      = 0;
    op_k         = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset:outputs",
        {cmd_ready, step_start, step_in_data, result_valid, result_data,
         result_err, result_steps, busy},
        {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0});
    rst = 1'b0;
    @(posedge clk);
    #1;

    // seed 3, three doubling steps of latency 1
    plan_lat  = {1, 1, 1};
    plan_spur = {0, 0, 0};
    run_cmd("x2_three", 8'd3, 3, 0, 8'h00, 0);

    plan_lat  = {1};
    plan_spur = {0};
    run_cmd("x2_wrap", 8'h81, 1, 0, 8'h00, 0);

    plan_lat  = {};
    plan_spur = {};
    run_cmd("zero_steps", 8'd5, 0, 0, 8'h00, 1);

    plan_lat  = {NEVER, 1};
    plan_spur = {0, 0};
    run_cmd("timeout", 8'd7, 2, 0, 8'h00, 0);

    // done exactly on expiry counts; one cycle later is a timeout
    plan_lat  = {TIMEOUT, TIMEOUT + 1};
    plan_spur = {0, 0};
    run_cmd("expiry_edge_hold", 8'h11, 2, 1, 8'h03, 10);

    plan_lat  = {2, 1, 3};
    plan_spur = {1, 1, 1};
    run_cmd("done_in_issue", 8'h5a, 3, 2, 8'hc3, 2);

    plan_lat  = {};
    plan_spur = {};
    for (int i = 0; i < 15; i++) begin
      plan_lat.push_back(1);
      plan_spur.push_back(0);
    end
    run_cmd("max_steps", 8'd250, 15, 1, 8'h01, 0);

    // reset in the middle of a step wait
    lat_q   = {5, 5, 5};
    spur_q  = {0, 0, 0};
    op_mode = 0;
    cmd_valid = 1'b1;
    cmd_data  = 8'h42;
    cmd_steps = 4'd3;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrun:busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_reset:outputs",
        {cmd_ready, step_start, step_in_data, result_valid, result_data,
         result_err, result_steps, busy},
        {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat_q.delete();
    spur_q.delete();
    @(posedge clk);
    #1;
    plan_lat  = {1, 2};
    plan_spur = {0, 0};
    run_cmd("after_reset", 8'h42, 2, 0, 8'h00, 0);

    for (int c = 0; c < 40; c++) begin
      int n;
      n = ($urandom_range(9) == 0) ? 15 : $urandom_range(6);
      plan_lat  = {};
      plan_spur = {};
      for (int i = 0; i < n; i++) begin
        plan_lat.push_back(pick_lat());
        plan_spur.push_back($urandom_range(3) == 0);
      end
      run_cmd("random", 8'($urandom), n, $urandom_range(2), 8'($urandom),
              $urandom_range(3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
